// File: rtl/bytewrite_sdp_ram_arbiter_if.sv
// Bus bundle between the RAM front-end arbiter (slave side) and its requesters plus RAM (master side).
interface bytewrite_sdp_ram_arbiter_if #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH
);
  logic                  init_done;
  logic                  w0_req, w1_req;
  logic [ADDR_WIDTH-1:0] w0_addr, w1_addr;
  logic [NUM_COL-1:0]    w0_be, w1_be;
  logic [DATA_WIDTH-1:0] w0_data, w1_data;
  logic                  w0_gnt, w1_gnt;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt, rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  ram_ena;
  logic [NUM_COL-1:0]    ram_we;
  logic [ADDR_WIDTH-1:0] ram_write_addr, ram_read_addr;
  logic [DATA_WIDTH-1:0] ram_din, ram_dout;

  modport slave (
    output init_done, w0_gnt, w1_gnt, rd_gnt, rd_valid, rd_data,
           ram_ena, ram_we, ram_write_addr, ram_read_addr, ram_din,
    input  w0_req, w1_req, w0_addr, w1_addr, w0_be, w1_be, w0_data, w1_data,
           rd_req, rd_addr, ram_dout
  );

  modport master (
    input  init_done, w0_gnt, w1_gnt, rd_gnt, rd_valid, rd_data,
           ram_ena, ram_we, ram_write_addr, ram_read_addr, ram_din,
    output w0_req, w1_req, w0_addr, w1_addr, w0_be, w1_be, w0_data, w1_data,
           rd_req, rd_addr, ram_dout
  );
endinterface

// File: rtl/bytewrite_sdp_ram_arbiter.sv
// Zero-fills a byte-write SDP RAM after reset, then round-robins two writers onto its write port.
// Optional macro ARB_RD_BYPASS_EN: same-cycle write/read collisions return write-first data.
module bytewrite_sdp_ram_arbiter #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic clk,
  input  logic rst,
  bytewrite_sdp_ram_arbiter_if.slave bus
);
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  last_w1_q, last_w1_d;
  logic                  rd_valid_q;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [NUM_COL-1:0]    we_c;
  logic                  run, g0, g1, grd;

  always_comb begin
    run = (state_q == S_RUN) && !rst;
    // On contention the requester that did not win most recently goes first.
    g0  = run && bus.w0_req && (!bus.w1_req || last_w1_q);
    g1  = run && bus.w1_req && (!bus.w0_req || !last_w1_q);
    grd = run && bus.rd_req;

    state_d   = state_q;
    cnt_d     = cnt_q;
    last_w1_d = last_w1_q;
    waddr_d   = waddr_q;
    raddr_d   = raddr_q;
    din_d     = din_q;
    we_c      = '0;
    if (state_q == S_INIT) begin
      waddr_d = cnt_q;
      din_d   = '0;
      we_c    = '1;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = S_RUN;
    end else if (g0) begin
      waddr_d   = bus.w0_addr;
      din_d     = bus.w0_data;
      we_c      = bus.w0_be;
      last_w1_d = 1'b0;
    end else if (g1) begin
      waddr_d   = bus.w1_addr;
      din_d     = bus.w1_data;
      we_c      = bus.w1_be;
      last_w1_d = 1'b1;
    end
    if (grd) raddr_d = bus.rd_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      last_w1_q  <= 1'b1;
      rd_valid_q <= 1'b0;
      waddr_q    <= '0;
      raddr_q    <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_w1_q  <= last_w1_d;
      rd_valid_q <= grd;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      din_q      <= din_d;
    end
  end

  assign bus.init_done      = (state_q == S_RUN);
  assign bus.w0_gnt         = g0;
  assign bus.w1_gnt         = g1;
  assign bus.rd_gnt         = grd;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.ram_ena        = (state_q == S_INIT) || g0 || g1 || grd;
  assign bus.ram_we         = we_c;
  assign bus.ram_write_addr = waddr_d;
  assign bus.ram_read_addr  = raddr_d;
  assign bus.ram_din        = din_d;

`ifdef ARB_RD_BYPASS_EN
  logic                  byp_hit_q;
  logic [NUM_COL-1:0]    byp_be_q;
  logic [DATA_WIDTH-1:0] byp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_hit_q  <= 1'b0;
      byp_be_q   <= '0;
      byp_data_q <= '0;
    end else begin
      byp_hit_q  <= grd && (g0 || g1) && (bus.rd_addr == waddr_d);
      byp_be_q   <= we_c;
      byp_data_q <= din_d;
    end
  end

  for (genvar c = 0; c < NUM_COL; c++) begin : g_byp
    assign bus.rd_data[c*COL_WIDTH +: COL_WIDTH] = (byp_hit_q && byp_be_q[c]) ?
        byp_data_q[c*COL_WIDTH +: COL_WIDTH] : bus.ram_dout[c*COL_WIDTH +: COL_WIDTH];
  end
`else
  assign bus.rd_data = bus.ram_dout;
`endif
endmodule

// File: tb/tb_bytewrite_sdp_ram_arbiter.sv
// Bench for bytewrite_sdp_ram_arbiter: RAM behaviour model, shadow-memory reference, directed vectors.
module tb_bytewrite_sdp_ram_arbiter;
  localparam int NC = 4, CW = 8, AW = 10, DW = 32, DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bytewrite_sdp_ram_arbiter_if #(.NUM_COL(NC), .COL_WIDTH(CW), .ADDR_WIDTH(AW)) bus ();
  bytewrite_sdp_ram_arbiter #(.NUM_COL(NC), .COL_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Byte-write, read-first RAM attached to the arbiter.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_ena) begin
      bus.ram_dout <= ram[bus.ram_read_addr];
      for (int i = 0; i < NC; i++)
        if (bus.ram_we[i]) ram[bus.ram_write_addr][i*CW +: CW] <= bus.ram_din[i*CW +: CW];
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: cycles since reset, who won last, shadow memory, one pending read.
  bit            mvalid = 0;
  int            k = 0;
  bit            last_w1 = 1;
  bit            pend = 0;
  logic [DW-1:0] pend_data;
  logic [DW-1:0] mem [DEPTH];

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [NC-1:0] be);
    merge = o;
    for (int i = 0; i < NC; i++) if (be[i]) merge[i*CW +: CW] = n[i*CW +: CW];
  endfunction

  task automatic arb(output bit e0, output bit e1, output bit er);
    bit running;
    running = mvalid && !rst && (k >= DEPTH);
    e0 = 0; e1 = 0;
    if (running && bus.w0_req && bus.w1_req) begin
      if (last_w1) e0 = 1; else e1 = 1;
    end else if (running) begin
      e0 = bus.w0_req;
      e1 = bus.w1_req;
    end
    er = running && bus.rd_req;
  endtask

  task automatic compare();
    bit e0, e1, er;
    arb(e0, e1, er);
    if (!mvalid) return;
    chk("w0_gnt", bus.w0_gnt, e0);
    chk("w1_gnt", bus.w1_gnt, e1);
    chk("rd_gnt", bus.rd_gnt, er);
    if (e0 && e1) chk("both_gnt", 1, 0);
    if (rst) return;
    chk("init_done", bus.init_done, k >= DEPTH);
    if (k < DEPTH) begin
      chk("fill_ena", bus.ram_ena, 1);
      chk("fill_we", bus.ram_we, 4'hF);
      chk("fill_din", bus.ram_din, 0);
      chk("fill_addr", bus.ram_write_addr, k);
    end else begin
      chk("ram_ena", bus.ram_ena, e0 | e1 | er);
      if (e0 | e1) begin
        chk("ram_write_addr", bus.ram_write_addr, e0 ? bus.w0_addr : bus.w1_addr);
        chk("ram_we", bus.ram_we, e0 ? bus.w0_be : bus.w1_be);
        chk("ram_din", bus.ram_din, e0 ? bus.w0_data : bus.w1_data);
      end
      if (er) chk("ram_read_addr", bus.ram_read_addr, bus.rd_addr);
    end
    chk("rd_valid", bus.rd_valid, pend);
    if (pend) chk("rd_data", bus.rd_data, pend_data);
  endtask

  task automatic model_edge();
    bit e0, e1, er;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [NC-1:0] wb;
    arb(e0, e1, er);
    if (rst) begin
      mvalid = 1; k = 0; last_w1 = 1; pend = 0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      return;
    end
    if (!mvalid) return;
    if (k < DEPTH) begin
      k++;
      pend = 0;
      return;
    end
    wa = e0 ? bus.w0_addr : bus.w1_addr;
    wd = e0 ? bus.w0_data : bus.w1_data;
    wb = e0 ? bus.w0_be : bus.w1_be;
    pend = er;
    if (er) begin
      pend_data = mem[bus.rd_addr];
`ifdef ARB_RD_BYPASS_EN
      if ((e0 | e1) && bus.rd_addr == wa) pend_data = merge(pend_data, wd, wb);
`endif
    end
    if (e0 | e1) begin
      mem[wa] = merge(mem[wa], wd, wb);
      last_w1 = e1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    bus.w0_req = 0; bus.w1_req = 0; bus.rd_req = 0;
  endtask

  initial begin
    logic [DW-1:0] exp5;
    bus.w0_req = 0; bus.w0_addr = '0; bus.w0_be = '0; bus.w0_data = '0;
    bus.w1_req = 0; bus.w1_addr = '0; bus.w1_be = '0; bus.w1_data = '0;
    bus.rd_req = 0; bus.rd_addr = '0;

    // Reset and zero-fill
    rst = 1; step(); rst = 0;
    repeat (DEPTH - 1) step();
    chk("init_done_early", bus.init_done, 0);
    step();
    chk("init_done_at_1024", bus.init_done, 1);

    // Read of freshly filled location
    bus.rd_req = 1; bus.rd_addr = 300; step(); idle_in();
    chk("rd300_valid", bus.rd_valid, 1);
    chk("rd300_data", bus.rd_data, 32'h0);

    // Single writer, then read back
    bus.w0_req = 1; bus.w0_addr = 5; bus.w0_data = 32'hDEADBEEF; bus.w0_be = 4'hF;
    #1 chk("w0_single_gnt", bus.w0_gnt, 1);
    step(); idle_in();
    bus.rd_req = 1; bus.rd_addr = 5; step(); idle_in();
    chk("rd5_data", bus.rd_data, 32'hDEADBEEF);

    // Partial byte write merge
    bus.w1_req = 1; bus.w1_addr = 9; bus.w1_data = 32'h11223344; bus.w1_be = 4'hF; step();
    bus.w1_data = 32'hAABBCCDD; bus.w1_be = 4'b0101; step(); idle_in();
    bus.rd_req = 1; bus.rd_addr = 9; step(); idle_in();
    chk("rd9_merge", bus.rd_data, 32'h11BB33DD);

    // be=0 is still granted but writes nothing
    bus.w0_req = 1; bus.w0_addr = 9; bus.w0_data = 32'hFFFFFFFF; bus.w0_be = 4'h0;
    #1 chk("be0_gnt", bus.w0_gnt, 1);
    chk("be0_we", bus.ram_we, 4'h0);
    step(); idle_in();
    bus.rd_req = 1; bus.rd_addr = 9; step(); idle_in();
    chk("rd9_after_be0", bus.rd_data, 32'h11BB33DD);

    // Same-cycle write and read collision
    bus.w0_req = 1; bus.w0_addr = 7; bus.w0_data = 32'hCAFEF00D; bus.w0_be = 4'hF;
    bus.rd_req = 1; bus.rd_addr = 7; step(); idle_in();
`ifdef ARB_RD_BYPASS_EN
    exp5 = 32'hCAFEF00D;
`else
    exp5 = 32'h0;
`endif
    chk("collide_rd7", bus.rd_data, exp5);
    bus.rd_req = 1; bus.rd_addr = 7; step(); idle_in();
    chk("later_rd7", bus.rd_data, 32'hCAFEF00D);

    // Reset with a read in flight and another requested
    bus.rd_req = 1; bus.rd_addr = 3; step();
    rst = 1;
    #1 chk("rst_rd_gnt", bus.rd_gnt, 0);
    step(); rst = 0;
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_init_done", bus.init_done, 0);
    chk("rst_fill_addr0", bus.ram_write_addr, 0);
    step(); idle_in();
    repeat (DEPTH - 2) step();
    chk("reinit_early", bus.init_done, 0);
    step();
    chk("reinit_done", bus.init_done, 1);

    // Contention right after init: w0,w1,w0,w1
    bus.w0_req = 1; bus.w0_addr = 20; bus.w0_data = 32'h01020304; bus.w0_be = 4'hF;
    bus.w1_req = 1; bus.w1_addr = 21; bus.w1_data = 32'h0A0B0C0D; bus.w1_be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_w0_%0d", i), bus.w0_gnt, (i % 2) == 0);
      chk($sformatf("rr_w1_%0d", i), bus.w1_gnt, (i % 2) == 1);
      step();
    end
    idle_in();
    bus.rd_req = 1; bus.rd_addr = 21; step(); idle_in();
    chk("rd21", bus.rd_data, 32'h0A0B0C0D);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
